fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of requester and FIFO write data.
REQ-002 Parameter CNT_WIDTH, default 8, width of STALL_CNT.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-low.
REQ-005 REQ0_VLD  input  1  requester 0 has a word to write.
REQ-006 REQ0_DATA  input  DATA_WIDTH  requester 0 word.
REQ-007 REQ0_RDY  output  1  requester 0 word accepted this cycle (combinational).
REQ-008 REQ1_VLD  input  1  requester 1 has a word to write.
REQ-009 REQ1_DATA  input  DATA_WIDTH  requester 1 word.
REQ-010 REQ1_RDY  output  1  requester 1 word accepted this cycle (combinational).
REQ-011 W_FULL  input  1  FIFO full flag, write-clock domain.
REQ-012 W_INC  output  1  FIFO write request, registered state decode.
REQ-013 W_DATA  output  DATA_WIDTH  FIFO write data, registered.
REQ-014 STALL_CNT  output  CNT_WIDTH  saturating count of stalled push cycles.

Function
REQ-015 FSM states: IDLE (no word held) and PUSH (word held in W_DATA, W_INC=1); W_INC SHALL be 1 exactly when state is PUSH.
REQ-016 ACCEPT SHALL equal (state==IDLE) or (state==PUSH and W_FULL==0).
REQ-017 Transfer on requester k SHALL occur in a cycle where REQk_VLD=1 and REQk_RDY=1; REQk_RDY SHALL be 1 only if ACCEPT=1 and k is granted.
REQ-018 Grant: if exactly one VLD is 1, that requester is granted; if both, the requester indicated by priority pointer PRI is granted; neither VLD -> no grant, both RDY=0.
REQ-019 PRI SHALL toggle to the non-granted requester on every transfer; unchanged otherwise.
REQ-020 On transfer, W_DATA SHALL load the granted REQk_DATA at that edge and state SHALL be PUSH next cycle.
REQ-021 PUSH with W_FULL=0 is a completed FIFO write; without a new transfer in that cycle, state SHALL go IDLE; with one, state stays PUSH with new data (back-to-back, one word per cycle).
REQ-022 PUSH with W_FULL=1: W_DATA and W_INC SHALL hold, both RDY=0, no word lost or duplicated.
REQ-023 Requesters are not required to keep VLD low after RDY; a held VLD is a new word each accepted cycle.
REQ-024 REQk_DATA changes while VLD=1 and RDY=0 are legal; the value at the transfer edge is used.
REQ-025 W_FULL is sampled only in PUSH; its value in IDLE has no effect.

Reset
REQ-026 RST=0 SHALL asynchronously force state IDLE, W_INC=0, W_DATA=0, PRI=requester 0, STALL_CNT=0.
REQ-027 A word held in PUSH at reset assertion SHALL be discarded; no W_INC after release until a new transfer.
REQ-028 REQ0_RDY and REQ1_RDY SHALL be 0 while RST=0.

Configuration
REQ-029 Macro FIFO_ARB_STALL_CNT_EN: defined -> STALL_CNT increments by 1 each cycle with state PUSH and W_FULL=1, saturates at all-ones, never wraps, cleared only by reset.
REQ-030 Without FIFO_ARB_STALL_CNT_EN, STALL_CNT SHALL be constant 0 and no counter register SHALL be instantiated; all other behaviour identical.

Verification
REQ-031 Reset release, REQ0_VLD=1 DATA=0x11 one cycle, W_FULL=0 -> REQ0_RDY=1 that cycle; next cycle W_INC=1, W_DATA=0x11; following cycle W_INC=0.
REQ-032 Both VLD held 4 cycles, DATA0=0xA0, DATA1=0xB0, W_FULL=0 -> grants 0,1,0,1; W_DATA sequence 0xA0,0xB0,0xA0,0xB0 on consecutive cycles with W_INC=1.
REQ-033 Word 0x55 in PUSH, W_FULL=1 for 3 cycles, REQ1_VLD=1 -> W_DATA=0x55 held, RDY=0 for 3 cycles, then 0x55 written once and REQ1 accepted same cycle.
REQ-034 With FIFO_ARB_STALL_CNT_EN, CNT_WIDTH=8, W_FULL=1 in PUSH for 300 cycles -> STALL_CNT=255 held; without macro STALL_CNT=0 throughout.
REQ-035 RST asserted mid-PUSH with W_DATA=0x3C -> W_INC=0, W_DATA=0 immediately; after release, PRI=0 and REQ0 wins a simultaneous request.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin arbiter feeding a FIFO write port through a one-word push register.
// Optional stall counter enabled by defining FIFO_ARB_STALL_CNT_EN.
module fifo_wr_arbiter #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ0_VLD,
   input  logic [DATA_WIDTH-1:0] REQ0_DATA,
   output logic                  REQ0_RDY,
   input  logic                  REQ1_VLD,
   input  logic [DATA_WIDTH-1:0] REQ1_DATA,
   output logic                  REQ1_RDY,
   input  logic                  W_FULL,
   output logic                  W_INC,
   output logic [DATA_WIDTH-1:0] W_DATA,
   output logic [CNT_WIDTH-1:0]  STALL_CNT
);

   typedef enum logic {IDLE, PUSH} state_t;

   state_t                state, state_nxt;
   logic                  pri;
   logic                  accept;
   logic                  gnt0, gnt1;
   logic                  xfer;
   logic [DATA_WIDTH-1:0] data_sel;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state  <= IDLE;
         W_DATA <= '0;
         pri    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (xfer) begin
            W_DATA <= data_sel;
            pri    <= gnt0;
         end
      end
   end

   // RDY is gated by RST so nothing is accepted while reset holds state in IDLE
   always_comb begin
      accept    = (state == IDLE) || !W_FULL;
      gnt0      = REQ0_VLD && (!REQ1_VLD || !pri);
      gnt1      = REQ1_VLD && (!REQ0_VLD || pri);
      REQ0_RDY  = RST && accept && gnt0;
      REQ1_RDY  = RST && accept && gnt1;
      xfer      = REQ0_RDY || REQ1_RDY;
      data_sel  = gnt0 ? REQ0_DATA : REQ1_DATA;
      W_INC     = (state == PUSH);
      state_nxt = IDLE;
      if (xfer || (state == PUSH && W_FULL)) begin
         state_nxt = PUSH;
      end
   end

`ifdef FIFO_ARB_STALL_CNT_EN
   logic [CNT_WIDTH-1:0] stall_cnt;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         stall_cnt <= '0;
      end else if (state == PUSH && W_FULL && stall_cnt != '1) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign STALL_CNT = stall_cnt;
`else
   assign STALL_CNT = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a queue-based reference model.
// Honours FIFO_ARB_STALL_CNT_EN when the same macro is defined for the bench.
module tb_fifo_wr_arbiter;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       REQ0_VLD = 1'b0, REQ1_VLD = 1'b0, W_FULL = 1'b0;
   logic [7:0] REQ0_DATA = '0, REQ1_DATA = '0;
   logic       REQ0_RDY, REQ1_RDY, W_INC;
   logic [7:0] W_DATA;
   logic [7:0] STALL_CNT;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // reference model: words accepted but not yet written, last accepted word, priority, stall count
   logic [7:0]  pend_q[$];
   logic [7:0]  m_held;
   int unsigned m_pri;
   int unsigned m_stall;

   fifo_wr_arbiter #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
      .CLK(CLK), .RST(RST),
      .REQ0_VLD(REQ0_VLD), .REQ0_DATA(REQ0_DATA), .REQ0_RDY(REQ0_RDY),
      .REQ1_VLD(REQ1_VLD), .REQ1_DATA(REQ1_DATA), .REQ1_RDY(REQ1_RDY),
      .W_FULL(W_FULL), .W_INC(W_INC), .W_DATA(W_DATA), .STALL_CNT(STALL_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      pend_q.delete();
      m_held  = '0;
      m_pri   = 0;
      m_stall = 0;
   endfunction

   // one cycle: drive at negedge, check at negedge+1, advance model for the coming posedge
   task automatic step(input logic v0, input logic [7:0] d0, input logic v1,
                       input logic [7:0] d1, input logic full);
      int  g;
      bit  take, writes;
      @(negedge CLK);
      REQ0_VLD = v0; REQ0_DATA = d0; REQ1_VLD = v1; REQ1_DATA = d1; W_FULL = full;
      #1;
      writes = (pend_q.size() != 0) && !full;
      take   = (pend_q.size() == 0) || writes;
      g = -1;
      if (v0 && v1)  g = int'(m_pri);
      else if (v0)   g = 0;
      else if (v1)   g = 1;
      if (!take) g = -1;
      check("w_inc",  32'(W_INC),    32'(pend_q.size() != 0));
      check("w_data", 32'(W_DATA),   32'(m_held));
      check("rdy0",   32'(REQ0_RDY), 32'(g == 0));
      check("rdy1",   32'(REQ1_RDY), 32'(g == 1));
`ifdef FIFO_ARB_STALL_CNT_EN
      check("stall",  32'(STALL_CNT), 32'(m_stall));
`else
      check("stall",  32'(STALL_CNT), 32'd0);
`endif
      if (pend_q.size() != 0 && full && m_stall < 255) m_stall++;
      if (writes) void'(pend_q.pop_front());
      if (g >= 0) begin
         m_held = (g == 0) ? d0 : d1;
         pend_q.push_back(m_held);
         m_pri  = (g == 0) ? 1 : 0;
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b0;
      REQ0_VLD = 1'b1; REQ1_VLD = 1'b1;
      #1;
      check("rst_w_inc", 32'(W_INC),    32'd0);
      check("rst_w_data", 32'(W_DATA),  32'd0);
      check("rst_rdy0", 32'(REQ0_RDY), 32'd0);
      check("rst_rdy1", 32'(REQ1_RDY), 32'd0);
      check("rst_stall", 32'(STALL_CNT), 32'd0);
      model_reset();
      @(negedge CLK);
      RST = 1'b1;
      REQ0_VLD = 1'b0; REQ1_VLD = 1'b0;
   endtask

   initial begin
      model_reset();
      do_reset();

      // single word from requester 0
      step(1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
      check("r031_rdy0", 32'(REQ0_RDY), 32'd1);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      check("r031_inc", 32'(W_INC), 32'd1);
      check("r031_data", 32'(W_DATA), 32'h11);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      check("r031_idle", 32'(W_INC), 32'd0);

      // alternating grants under simultaneous requests
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b0);
         check("r032_rdy0", 32'(REQ0_RDY), 32'(i % 2 == 0));
         if (i > 0) check("r032_data", 32'(W_DATA), (i % 2 == 1) ? 32'hA0 : 32'hB0);
      end
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      check("r032_last", 32'(W_DATA), 32'hB0);

      // held word while FIFO is full
      do_reset();
      step(1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'h00, 1'b1, 8'h70 + 8'(i), 1'b1);
         check("r033_hold", 32'(W_DATA), 32'h55);
         check("r033_rdy1", 32'(REQ1_RDY), 32'd0);
      end
      step(1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
      check("r033_write", 32'(W_INC), 32'd1);
      check("r033_acc", 32'(REQ1_RDY), 32'd1);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("r033_next", 32'(W_DATA), 32'h77);

      // long stall saturates the counter
      for (int i = 0; i < 300; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
`ifdef FIFO_ARB_STALL_CNT_EN
      check("r034_sat", 32'(STALL_CNT), 32'd255);
`else
      check("r034_zero", 32'(STALL_CNT), 32'd0);
`endif
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

      // reset in the middle of a push, then priority back at requester 0
      step(1'b0, 8'h00, 1'b1, 8'h3C, 1'b0);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("r035_pre", 32'(W_DATA), 32'h3C);
      do_reset();
      step(1'b1, 8'h01, 1'b1, 8'h02, 1'b0);
      check("r035_win0", 32'(REQ0_RDY), 32'd1);

      // random traffic with occasional resets
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(99) == 0) do_reset();
         step(1'($urandom_range(99) < 60), 8'($urandom), 1'($urandom_range(99) < 60),
              8'($urandom), 1'($urandom_range(99) < 30));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
